// File: rtl/bpu_stat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpu_stat_pkg
// Description : Shared class indices and dump FSM encoding for bpu_stat_ctr.
// Revision    : 1.0 - initial release
// ============================================================================
package bpu_stat_pkg;

    // Instruction classes as assigned by the decode stage (RET = JALR rs1=x1)
    localparam int unsigned CLS_JAL  = 0;
    localparam int unsigned CLS_JALR = 1;
    localparam int unsigned CLS_RET  = 2;
    localparam int unsigned CLS_BEQ  = 3;
    localparam int unsigned CLS_BNE  = 4;
    localparam int unsigned CLS_BLT  = 5;
    localparam int unsigned CLS_BGE  = 6;
    localparam int unsigned CLS_BLTU = 7;
    localparam int unsigned CLS_BGEU = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DUMP = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage : bpu_stat_pkg
`default_nettype wire

// File: rtl/bpu_sat_ctr.sv
`default_nettype none
// ============================================================================
// Module      : bpu_sat_ctr
// Description : Single saturating up-counter with a sat_hit pulse on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_sat_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] val,
    output logic             sat_hit
);

    logic [CNT_W-1:0] r_val;
    logic             w_full;

    assign w_full = &r_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_val <= '0;
        end else if (clr) begin
            r_val <= '0;
        end else if (inc && !w_full) begin
            r_val <= r_val + 1'b1;
        end
    end

    // An increment that arrives while already at the ceiling is the overflow event
    assign sat_hit = inc && w_full;
    assign val     = r_val;

endmodule : bpu_sat_ctr
`default_nettype wire

// File: rtl/bpu_stat_ctr.sv
`default_nettype none
// ============================================================================
// Module      : bpu_stat_ctr
// Description : Per-class branch/jump commit and mispredict statistics with a
//               valid/ready end-of-run dump port.
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_stat_ctr
    import bpu_stat_pkg::*;
#(
    parameter int NUM_CLS = 9,
    parameter int CNT_W   = 32,
    parameter int CLS_W   = $clog2(NUM_CLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmt_vld,
    input  logic [CLS_W-1:0]   cmt_cls,
    input  logic               cmt_miss,
    input  logic               clr,
    input  logic               core_end,
    output logic               dump_vld,
    input  logic               dump_rdy,
    output logic [CLS_W-1:0]   dump_idx,
    output logic [CNT_W-1:0]   dump_all,
    output logic [CNT_W-1:0]   dump_miss,
    output logic               dump_last,
    output logic               dump_done,
    output logic [NUM_CLS-1:0] sat_flag
);

    localparam logic [CLS_W-1:0] C_LAST = CLS_W'(NUM_CLS - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CLS_W-1:0]   r_ptr;
    logic [CLS_W-1:0]   w_ptr_nxt;
    logic [NUM_CLS-1:0] r_sat_flag;

    logic               w_cmt_ok;
    logic [NUM_CLS-1:0] w_inc_all;
    logic [NUM_CLS-1:0] w_inc_miss;
    logic [NUM_CLS-1:0] w_hit_all;
    logic [NUM_CLS-1:0] w_hit_miss;
    logic [CNT_W-1:0]   w_all_val  [NUM_CLS];
    logic [CNT_W-1:0]   w_miss_val [NUM_CLS];

    // Counters only move in IDLE so a dump always sees a frozen snapshot
    assign w_cmt_ok = cmt_vld && !clr && (r_state == IDLE);

    for (genvar g = 0; g < NUM_CLS; g++) begin : g_cls
        assign w_inc_all[g]  = w_cmt_ok && (cmt_cls == CLS_W'(g));
        assign w_inc_miss[g] = w_inc_all[g] && cmt_miss;

        bpu_sat_ctr #(
            .CNT_W   (CNT_W)
        ) u_all_ctr (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .inc     (w_inc_all[g]),
            .val     (w_all_val[g]),
            .sat_hit (w_hit_all[g])
        );

        bpu_sat_ctr #(
            .CNT_W   (CNT_W)
        ) u_miss_ctr (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .inc     (w_inc_miss[g]),
            .val     (w_miss_val[g]),
            .sat_hit (w_hit_miss[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_flag <= '0;
        end else if (clr) begin
            r_sat_flag <= '0;
        end else begin
            r_sat_flag <= r_sat_flag | w_hit_all | w_hit_miss;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (core_end) begin
                    w_state_nxt = DUMP;
                    w_ptr_nxt   = '0;
                end
            end
            DUMP: begin
                if (dump_rdy) begin
                    if (r_ptr == C_LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
        if (clr) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = '0;
        end
    end

    assign dump_vld  = (r_state == DUMP);
    assign dump_done = (r_state == DONE);
    assign dump_last = dump_vld && (r_ptr == C_LAST);
    assign dump_idx  = r_ptr;
    assign dump_all  = w_all_val[r_ptr];
    assign dump_miss = w_miss_val[r_ptr];
    assign sat_flag  = r_sat_flag;

endmodule : bpu_stat_ctr
`default_nettype wire

// File: tb/tb_bpu_stat_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpu_stat_ctr
// Description : Directed self-checking bench for bpu_stat_ctr (default, 8-bit
//               counter and 5-class configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpu_stat_ctr;

    logic        clk;
    logic        rst_n;
    logic        cmt_vld;
    logic [3:0]  cmt_cls;
    logic        cmt_miss;
    logic        clr;
    logic        core_end;
    logic        dump_rdy;

    logic        dump_vld, dump_last, dump_done;
    logic [3:0]  dump_idx;
    logic [31:0] dump_all, dump_miss;
    logic [8:0]  sat_flag;

    logic        d8_vld, d8_last, d8_done;
    logic [3:0]  d8_idx;
    logic [7:0]  d8_all, d8_miss;
    logic [8:0]  d8_sat;

    logic        p5_cmt_vld, p5_cmt_miss, p5_clr, p5_core_end, p5_rdy;
    logic [2:0]  p5_cmt_cls;
    logic        p5_vld, p5_last, p5_done;
    logic [2:0]  p5_idx;
    logic [31:0] p5_all, p5_miss;
    logic [4:0]  p5_sat;

    int n_tests = 0;
    int n_fail  = 0;

    bpu_stat_ctr dut (
        .clk(clk), .rst_n(rst_n), .cmt_vld(cmt_vld), .cmt_cls(cmt_cls),
        .cmt_miss(cmt_miss), .clr(clr), .core_end(core_end),
        .dump_vld(dump_vld), .dump_rdy(dump_rdy), .dump_idx(dump_idx),
        .dump_all(dump_all), .dump_miss(dump_miss), .dump_last(dump_last),
        .dump_done(dump_done), .sat_flag(sat_flag)
    );

    bpu_stat_ctr #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .cmt_vld(cmt_vld), .cmt_cls(cmt_cls),
        .cmt_miss(cmt_miss), .clr(clr), .core_end(core_end),
        .dump_vld(d8_vld), .dump_rdy(dump_rdy), .dump_idx(d8_idx),
        .dump_all(d8_all), .dump_miss(d8_miss), .dump_last(d8_last),
        .dump_done(d8_done), .sat_flag(d8_sat)
    );

    bpu_stat_ctr #(.NUM_CLS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .cmt_vld(p5_cmt_vld), .cmt_cls(p5_cmt_cls),
        .cmt_miss(p5_cmt_miss), .clr(p5_clr), .core_end(p5_core_end),
        .dump_vld(p5_vld), .dump_rdy(p5_rdy), .dump_idx(p5_idx),
        .dump_all(p5_all), .dump_miss(p5_miss), .dump_last(p5_last),
        .dump_done(p5_done), .sat_flag(p5_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [3:0] cls, input logic miss, input int n);
        for (int i = 0; i < n; i++) begin
            cmt_vld  = 1'b1;
            cmt_cls  = cls;
            cmt_miss = miss;
            tick();
        end
        cmt_vld  = 1'b0;
        cmt_miss = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Called with the default DUT already in DUMP; dump_rdy held high throughout
    task automatic dump_check(input string tag, input int hit, input logic [31:0] e_all,
                              input logic [31:0] e_miss);
        dump_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check({tag, "_vld"},  dump_vld, 1'b1);
            check({tag, "_idx"},  dump_idx, i);
            check({tag, "_all"},  dump_all, (i == hit) ? e_all : 32'd0);
            check({tag, "_miss"}, dump_miss, (i == hit) ? e_miss : 32'd0);
            check({tag, "_last"}, dump_last, (i == 8));
            tick();
        end
        check({tag, "_end_vld"}, dump_vld, 1'b0);
        check({tag, "_done"},    dump_done, 1'b1);
    endtask

    logic [3:0]  bp_pat;
    logic [3:0]  h_idx;
    logic [31:0] h_all, h_miss;
    logic        held;
    int          acc;

    initial begin
        rst_n = 1'b0; cmt_vld = 1'b0; cmt_cls = '0; cmt_miss = 1'b0;
        clr = 1'b0; core_end = 1'b0; dump_rdy = 1'b0;
        p5_cmt_vld = 1'b0; p5_cmt_cls = '0; p5_cmt_miss = 1'b0;
        p5_clr = 1'b0; p5_core_end = 1'b0; p5_rdy = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("rst_vld",  dump_vld, 1'b0);
        check("rst_done", dump_done, 1'b0);
        check("rst_last", dump_last, 1'b0);
        check("rst_idx",  dump_idx, 4'd0);
        check("rst_all",  dump_all, 32'd0);
        check("rst_miss", dump_miss, 32'd0);
        check("rst_sat",  sat_flag, 9'd0);

        // Basic count: 5 BEQ commits, 2 mispredicted
        commit(4'd3, 1'b1, 2);
        commit(4'd3, 1'b0, 3);
        core_end = 1'b1; dump_rdy = 1'b1;
        tick();
        core_end = 1'b0;
        dump_check("basic", 3, 32'd5, 32'd2);

        // Back-pressure: one commit per class, odd classes mispredicted
        do_clr();
        check("clr_done", dump_done, 1'b0);
        check("clr_idx",  dump_idx, 4'd0);
        for (int c = 0; c < 9; c++) commit(c[3:0], c[0], 1);
        core_end = 1'b1; dump_rdy = 1'b0;
        tick();
        core_end = 1'b0;
        bp_pat = 4'b1001;
        held = 1'b0; acc = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (dump_done) break;
            if (held) begin
                check("bp_hold_vld",  dump_vld, 1'b1);
                check("bp_hold_idx",  dump_idx, h_idx);
                check("bp_hold_all",  dump_all, h_all);
                check("bp_hold_miss", dump_miss, h_miss);
            end
            held = 1'b0;
            dump_rdy = bp_pat[cyc % 4];
            if (dump_vld && dump_rdy) begin
                check("bp_idx",  dump_idx, acc);
                check("bp_all",  dump_all, 32'd1);
                check("bp_miss", dump_miss, acc & 1);
                acc++;
            end else if (dump_vld) begin
                held = 1'b1; h_idx = dump_idx; h_all = dump_all; h_miss = dump_miss;
            end
            tick();
        end
        check("bp_count", acc, 9);
        check("bp_done",  dump_done, 1'b1);

        // Saturation: 260 missed JAL commits
        do_clr();
        commit(4'd0, 1'b1, 260);
        check("sat8_flag", d8_sat, 9'h001);
        check("sat32_flag", sat_flag, 9'h000);
        core_end = 1'b1; dump_rdy = 1'b1;
        tick();
        core_end = 1'b0;
        check("sat8_all",   d8_all, 8'd255);
        check("sat8_miss",  d8_miss, 8'd255);
        dump_check("sat32", 0, 32'd260, 32'd260);
        check("sat8_done", d8_done, 1'b1);

        // Freeze: commit alongside core_end counts, later ones are dropped
        do_clr();
        cmt_vld = 1'b1; cmt_cls = 4'd4; cmt_miss = 1'b0; core_end = 1'b1; dump_rdy = 1'b1;
        tick();
        core_end = 1'b0; cmt_miss = 1'b1;
        dump_check("frz", 4, 32'd1, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cmt_cls = i[0] ? 4'd8 : 4'd4;
            tick();
            check("frz_done_hold", dump_done, 1'b1);
            check("frz_done_all",  dump_all, 32'd0);
        end
        cmt_vld = 1'b0; cmt_miss = 1'b0;

        // Clear mid-dump with a saturated 8-bit counter present
        do_clr();
        commit(4'd0, 1'b1, 260);
        commit(4'd5, 1'b0, 1);
        core_end = 1'b1; dump_rdy = 1'b1;
        tick();
        core_end = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (dump_idx == 4'd4) break;
            tick();
        end
        check("mid_reach4", dump_idx, 4'd4);
        check("mid_sat_pre", d8_sat, 9'h001);
        do_clr();
        check("mid_vld",  dump_vld, 1'b0);
        check("mid_done", dump_done, 1'b0);
        check("mid_idx",  dump_idx, 4'd0);
        check("mid_all",  dump_all, 32'd0);
        check("mid_sat",  d8_sat, 9'h000);
        core_end = 1'b1;
        tick();
        core_end = 1'b0;
        dump_check("mid_redump", -1, 32'd0, 32'd0);

        // Illegal classes on the 5-class instance, then one legal commit
        p5_clr = 1'b1; tick(); p5_clr = 1'b0;
        p5_cmt_vld = 1'b1; p5_cmt_miss = 1'b1;
        p5_cmt_cls = 3'd6; tick();
        p5_cmt_cls = 3'd5; tick();
        p5_cmt_cls = 3'd7; tick();
        p5_cmt_cls = 3'd2; p5_cmt_miss = 1'b0; tick();
        p5_cmt_vld = 1'b0;
        check("ill_sat", p5_sat, 5'd0);
        p5_core_end = 1'b1; p5_rdy = 1'b1;
        tick();
        p5_core_end = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ill_idx",  p5_idx, i);
            check("ill_all",  p5_all, (i == 2) ? 32'd1 : 32'd0);
            check("ill_miss", p5_miss, 32'd0);
            check("ill_last", p5_last, (i == 4));
            tick();
        end
        check("ill_done", p5_done, 1'b1);

        // Reset mid-dump
        p5_clr = 1'b1; tick(); p5_clr = 1'b0;
        p5_cmt_vld = 1'b1; p5_cmt_cls = 3'd1; tick(); tick();
        p5_cmt_vld = 1'b0;
        p5_core_end = 1'b1; tick(); p5_core_end = 1'b0;
        tick();
        check("rmid_idx", p5_idx, 3'd1);
        check("rmid_all", p5_all, 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rmid_vld",  p5_vld, 1'b0);
        check("rmid_idx0", p5_idx, 3'd0);
        check("rmid_all0", p5_all, 32'd0);
        check("rmid_done", p5_done, 1'b0);
        check("rmid_dut_done", dump_done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bpu_stat_ctr
`default_nettype wire

// File: doc/bpu_stat_ctr.md
# bpu_stat_ctr

Parametrised branch/jump prediction statistics unit for the e203 debug path. It counts committed control-transfer instructions and their mispredictions per instruction class in saturating counters. At end of run it streams the per-class totals out over a valid/ready dump port, replacing the ad-hoc combinational print block. It sits beside the EXU commit stage, is simulation/debug-only, and never back-pressures the core.

## Interface
Parameters:
- NUM_CLS, 9: number of instruction classes counted. Legal range 2..16.
- CNT_W, 32: width of each total and miss counter. Legal range 8..64.
- CLS_W, $clog2(NUM_CLS): width of the class index. Derived; do not override.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous and active-low
- cmt_vld  in  1  one control-transfer instruction commits this cycle
- cmt_cls  in  CLS_W  class of the committing instruction; values ≥ NUM_CLS are ignored
- cmt_miss  in  1  the committing instruction was mispredicted; qualified by cmt_vld
- clr  in  1  synchronous clear of all counters, sat flags and the FSM
- core_end  in  1  end-of-run pulse; starts a dump
- dump_vld  out  1  dump record valid
- dump_rdy  in  1  consumer accepts the record
- dump_idx  out  CLS_W  class index of the current record
- dump_all  out  CNT_W  total count for dump_idx
- dump_miss  out  CNT_W  miss count for dump_idx
- dump_last  out  1  current record is class NUM_CLS-1
- dump_done  out  1  dump complete; high in the DONE state
- sat_flag  out  NUM_CLS  sticky per class: set when either counter of that class saturates

## Operation
- Per class c there are two counters, all[c] and miss[c]. When cmt_vld is high, cmt_cls equals c, the FSM is in IDLE and clr is low:
  - all[c] is incremented.
  - miss[c] is also incremented if cmt_miss is high.
- Counters saturate at 2^CNT_W−1 and do not wrap. Any increment attempted on a saturated counter sets sat_flag[c]. sat_flag[c] stays set until clr or reset.
- The two counters of a class saturate independently.
- FSM states are IDLE, DUMP and DONE.
  - IDLE → DUMP when core_end is high. The read pointer is loaded to 0.
  - In DUMP, dump_vld is high and the outputs show class ptr. A dump_vld & dump_rdy handshake advances ptr.
  - The handshake with ptr = NUM_CLS−1 moves the FSM to DONE.
  - DONE holds until clr, then returns to IDLE.
- Counters are frozen in DUMP and DONE. Commits arriving in those states are dropped, so the dump is a consistent snapshot.
- core_end is ignored outside IDLE.
- clr has priority over everything else. It zeroes all counters, sat_flag and ptr, and forces IDLE, including mid-dump.
- Any class index ≥ NUM_CLS on cmt_cls produces no update.

## Timing
- Reset values: every counter is 0, sat_flag is 0, the FSM is IDLE and ptr is 0. The outputs are dump_vld 0, dump_done 0, dump_last 0, dump_idx 0, dump_all 0, dump_miss 0.
- Counter update latency is 1 cycle. A commit at cycle t is visible in the counter at t+1.
- A commit in the same cycle as core_end is counted. The dump begins at t+1 and includes it.
- dump_vld rises 1 cycle after core_end.
- While dump_vld is high and dump_rdy is low, all dump_* outputs hold stable.
- With dump_rdy held high, one record transfers per cycle, so a full dump takes NUM_CLS cycles.
- When the last record is accepted at cycle t, dump_vld falls and dump_done rises, both at t+1.
- When clr is asserted at cycle t, every output is at its reset value at t+1.
- All dump_* outputs are registered or driven directly from registered state, with no input→output combinational path. dump_all and dump_miss may be mux reads of the counter array indexed by ptr.

## Structure
- Shared package bpu_stat_pkg holds:
  - class index constants: CLS_JAL=0, CLS_JALR=1, CLS_RET=2, CLS_BEQ=3, CLS_BNE=4, CLS_BLT=5, CLS_BGE=6, CLS_BLTU=7, CLS_BGEU=8;
  - the FSM state encoding: IDLE=2'd0, DUMP=2'd1, DONE=2'd2.
- The decode stage maps instructions to classes; this block never decodes instructions. RET is the JALR with rs1 = x1.
- One sub-module, bpu_sat_ctr, holds a single CNT_W saturating counter. Its ports are clr, inc and val, plus a sat_hit pulse. It is instantiated 2×NUM_CLS times.

## Test plan
- Basic count with defaults: 5 commits of CLS_BEQ, 2 of them with cmt_miss, then core_end with dump_rdy=1.
  - Record 3 shows all=5, miss=2.
  - All other records are 0.
  - dump_last is high only on idx 8.
  - dump_done rises the cycle after idx 8.
- Back-pressure: toggle dump_rdy 1-0-0-1 during the dump.
  - Outputs hold through the low cycles.
  - Exactly 9 records are accepted, with no duplicates and no skipped indices.
- Saturation with CNT_W=8: 260 commits of CLS_JAL, all missed.
  - all[0]=255 and miss[0]=255.
  - sat_flag=9'b000000001.
- Freeze: issue core_end, then commits on CLS_BNE during DUMP and DONE.
  - Dumped and post-DONE values are unchanged.
  - A same-cycle commit with core_end is counted: all[4]=1.
- Clear mid-dump: assert clr while dump_idx=4.
  - Next cycle: dump_vld=0, counters=0, sat_flag=0, FSM in IDLE.
  - A new core_end then dumps all zeros.
- Illegal class with NUM_CLS=5: cmt_cls=6 with cmt_vld=1 produces no change to any counter. Reset asserted mid-run gives reset values on the next cycle.
